// File: rtl/router_pkg.sv
// Shared constants for the router synchronizer family.
package router_pkg;
  localparam int ROUTER_NUM_CH_DEF  = 3;
  localparam int ROUTER_TIMEOUT_DEF = 30;
  localparam int DROP_CNT_W         = 8;
endpackage

// File: rtl/router_sync_timer.sv
// Per-channel unread-valid timer with one-cycle soft reset pulse.
// Optional saturating drop counter when ROUTER_SYNC_N_STATS_EN is defined.
module router_sync_timer
  import router_pkg::*;
#(
  parameter  int TIMEOUT = ROUTER_TIMEOUT_DEF,
  localparam int TMR_W   = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld,
  input  logic                  rd,
  output logic                  soft_reset,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             soft_reset_q, soft_reset_d;
  logic             stall;

  assign stall = vld & ~rd;

  // Timer clears on the pulse so a persistent stall pulses every TIMEOUT cycles.
  always_comb begin
    timer_d      = timer_q;
    soft_reset_d = 1'b0;
    if (!stall) begin
      timer_d = '0;
    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
      timer_d      = '0;
      soft_reset_d = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q      <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

`ifdef ROUTER_SYNC_N_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Counted on the same edge that raises the pulse; saturates at all-ones.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (soft_reset_d && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: rtl/router_sync_n.sv
// NUM_CH-channel router synchronizer: address capture/decode, valid, timeouts.
// Define ROUTER_SYNC_N_STATS_EN to build the per-channel drop counters.
module router_sync_n
  import router_pkg::*;
#(
  parameter  int NUM_CH  = ROUTER_NUM_CH_DEF,
  parameter  int TIMEOUT = ROUTER_TIMEOUT_DEF,
  localparam int ADDR_W  = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         detect_add,
  input  logic [ADDR_W-1:0]            data_in,
  input  logic                         write_enb_reg,
  input  logic [NUM_CH-1:0]            read_enb,
  input  logic [NUM_CH-1:0]            empty,
  input  logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            vld_out,
  output logic [NUM_CH-1:0]            write_enb,
  output logic                         fifo_full,
  output logic [NUM_CH-1:0]            soft_reset,
  output logic                         addr_err,
  output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_vld_q, addr_vld_d;
  logic              addr_err_q, addr_err_d;
  logic              in_range;
  logic [ADDR_W-1:0] eff_addr;
  logic              eff_vld;
  logic [NUM_CH-1:0] sel;

  // Widen before comparing: data_in can encode values beyond NUM_CH-1.
  assign in_range = (int'(data_in) < NUM_CH);

  always_comb begin
    addr_d     = addr_q;
    addr_vld_d = addr_vld_q;
    addr_err_d = 1'b0;
    if (detect_add) begin
      if (in_range) begin
        addr_d     = data_in;
        addr_vld_d = 1'b1;
      end else begin
        addr_vld_d = 1'b0;
        addr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_vld_q <= addr_vld_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Header cycle bypasses the register so the first write lands immediately.
  assign eff_addr = detect_add ? data_in : addr_q;
  assign eff_vld  = detect_add ? in_range : addr_vld_q;

  assign fifo_full = |(full & sel);
  assign vld_out   = ~empty;
  assign addr_err  = addr_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign sel[gi]       = eff_vld & (eff_addr == ADDR_W'(gi));
    assign write_enb[gi] = sel[gi] & write_enb_reg;

    router_sync_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clk        (clk),
      .rst        (reset),
      .vld        (vld_out[gi]),
      .rd         (read_enb[gi]),
      .soft_reset (soft_reset[gi]),
      .drop_cnt   (drop_cnt[gi*DROP_CNT_W +: DROP_CNT_W])
    );
  end

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised synchronizer between the router FSM and an array of NUM_CH output FIFOs. It holds the destination address captured at packet header time and steers the FSM's single write strobe and the selected FIFO's full flag. It drives each channel's valid output from FIFO empty and issues a one-cycle soft reset to any channel whose valid data is not read within TIMEOUT cycles. It generalises the fixed three-channel synchronizer and adds out-of-range address detection.

## Interface
Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16)
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (2..1023)
- ADDR_W, $clog2(NUM_CH), address width (localparam, derived)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- detect_add  in  1  header present on data_in this cycle
- data_in  in  ADDR_W  destination channel index
- write_enb_reg  in  1  FSM write strobe
- read_enb  in  NUM_CH  per-channel read enable from the reader
- empty  in  NUM_CH  per-channel FIFO empty
- full  in  NUM_CH  per-channel FIFO full
- vld_out  out  NUM_CH  per-channel valid
- write_enb  out  NUM_CH  one-hot (or zero) FIFO write enable
- fifo_full  out  1  full flag of the addressed FIFO
- soft_reset  out  NUM_CH  per-channel timeout pulse
- addr_err  out  1  out-of-range address pulse
- drop_cnt  out  NUM_CH*8  per-channel soft-reset count (see Configuration)

## Operation
- Address register addr_q (ADDR_W bits) plus addr_vld_q. Reset: addr_vld_q=0.
- detect_add=1, data_in<NUM_CH: addr_q<=data_in, addr_vld_q<=1.
- detect_add=1, data_in>=NUM_CH: addr_vld_q<=0, addr_err=1 on the next cycle for exactly one cycle.
- Effective address = detect_add ? data_in : addr_q, and it is valid only when in range (for data_in) or addr_vld_q=1 (for addr_q).
- Effective address valid: write_enb[addr]=write_enb_reg and fifo_full=full[addr]. Effective address invalid: write_enb=0 and fifo_full=0.
- vld_out[i] = ~empty[i] (combinational).
- Per-channel timer: cleared when vld_out[i]=0 or read_enb[i]=1. Otherwise increments. When it is TIMEOUT-1 and still incrementing, soft_reset[i]=1 next cycle and the timer clears to 0. The timer then restarts counting if the condition persists, so pulses repeat every TIMEOUT cycles.
- Channels are fully independent, so simultaneous timeouts on several channels all pulse in the same cycle.

## Timing
- Reset values: write_enb=0, fifo_full=0, soft_reset=0, addr_err=0, drop_cnt=0, all timers 0. vld_out follows empty even during reset.
- write_enb and fifo_full have zero latency from detect_add, data_in, write_enb_reg and full (same-cycle bypass).
- soft_reset is registered. It is asserted at edge N+TIMEOUT when the stall begins at edge N, and it is always exactly one cycle wide.
- addr_err is registered with 1-cycle latency.
- Timer width is $clog2(TIMEOUT). The timer never exceeds TIMEOUT-1 and never wraps.
- Reset asserted mid-packet: addr_vld_q clears asynchronously, so write_enb=0 until the next detect_add.

## Configuration
- ROUTER_SYNC_N_STATS_EN defined: drop_cnt[i*8+:8] is an 8-bit counter per channel that increments on each soft_reset[i] pulse and saturates at 255. It clears only on reset.
- ROUTER_SYNC_N_STATS_EN undefined: the counters are not built and drop_cnt is tied to 0.

## Structure
- Shared package router_pkg holds:
  - ROUTER_NUM_CH_DEF=3
  - ROUTER_TIMEOUT_DEF=30
  - DROP_CNT_W=8
- Sub-module router_sync_timer (one per channel, generate loop) contains the timer, soft_reset pulse and optional drop counter.
- Address register and decode stay in the top level.

## Test plan
- Reset, then detect_add=1 with data_in=1 and write_enb_reg=1 (NUM_CH=3) -> write_enb=3'b010 in the same cycle. With detect_add low afterwards, write_enb keeps following write_enb_reg on channel 1. full[1]=1 -> fifo_full=1.
- data_in=3 with NUM_CH=3 and detect_add=1 -> write_enb=0, fifo_full=0, and addr_err high for one cycle on the next edge.
- empty[0]=0 and read_enb[0]=0 held (TIMEOUT=30) -> soft_reset[0] is a single-cycle pulse 30 cycles after the stall starts, then another 30 cycles later. read_enb[0]=1 at cycle 20 -> no pulse, and the timer restarts.
- Channels 0 and 2 stalled starting on the same edge -> both soft_reset pulses coincide. Channel 1 stays 0.
- With ROUTER_SYNC_N_STATS_EN, channel 2 held stalled for 300 timeouts -> drop_cnt channel 2 = 255 (saturated). Reset asserted asynchronously mid-count -> all outputs at reset values immediately.
- Parameter sweep NUM_CH=8, TIMEOUT=2 -> data_in=7 gives write_enb=8'h80. A stalled channel pulses soft_reset every 2 cycles.
